// File: rtl/load_store_unit.sv
// Load/store unit that breaks LB/LH/LW/LBU/LHU/SB/SH/SW into little-endian byte
// transactions on a req/ack memory port and stalls the core for the whole access.
module load_store_unit #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [2:0]            funct3,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           rdata,
    output logic                  rdata_valid,
    output logic                  misaligned,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic                  mem_ack,
    input  logic [7:0]            mem_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]            r_state;
    logic                  r_write;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [1:0]            r_count;
    logic [31:0]           r_capture;
    logic                  r_err;
    logic [31:0]           r_rdata;

    logic                  w_access;
    logic                  w_bad_align;
    logic [1:0]            w_last_idx;
    logic [31:0]           w_capture_next;
    logic [31:0]           w_extended;
    logic                  w_unused_addr;

    // Only the low ADDR_WIDTH address bits reach the memory.
    assign w_unused_addr = &{1'b0, addr[31:ADDR_WIDTH]};

    always_comb begin
        w_bad_align = 1'b0;
        case (funct3[1:0])
            2'b00:   w_bad_align = 1'b0;
            2'b01:   w_bad_align = addr[0];
            2'b10:   w_bad_align = |addr[1:0];
            default: w_bad_align = 1'b1;
        endcase
    end

    always_comb begin
        w_last_idx = 2'd3;
        case (r_funct3[1:0])
            2'b00:   w_last_idx = 2'd0;
            2'b01:   w_last_idx = 2'd1;
            default: w_last_idx = 2'd3;
        endcase
    end

    // The final byte arrives on the same edge that enters DONE, so extension
    // works on the capture register with the incoming byte already merged in.
    always_comb begin
        w_capture_next = r_capture;
        w_capture_next[{r_count, 3'b000} +: 8] = mem_rdata;
    end

    always_comb begin
        w_extended = w_capture_next;
        case (r_funct3)
            3'b000:  w_extended = {{24{w_capture_next[7]}}, w_capture_next[7:0]};
            3'b001:  w_extended = {{16{w_capture_next[15]}}, w_capture_next[15:0]};
            3'b100:  w_extended = {24'd0, w_capture_next[7:0]};
            3'b101:  w_extended = {16'd0, w_capture_next[15:0]};
            default: w_extended = w_capture_next;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state   <= S_IDLE;
            r_write   <= 1'b0;
            r_funct3  <= 3'd0;
            r_base    <= '0;
            r_wdata   <= 32'd0;
            r_count   <= 2'd0;
            r_capture <= 32'd0;
            r_err     <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_write  <= req_write;
                        r_funct3 <= funct3;
                        r_base   <= addr[ADDR_WIDTH-1:0];
                        r_wdata  <= wdata;
                        r_count  <= 2'd0;
                        r_err    <= w_bad_align;
                        r_state  <= w_bad_align ? S_DONE : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!r_write) begin
                            r_capture <= w_capture_next;
                        end
                        if (r_count == w_last_idx) begin
                            r_state <= S_DONE;
                            if (!r_write) begin
                                r_rdata <= w_extended;
                            end
                        end else begin
                            r_count <= r_count + 2'd1;
                        end
                    end
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign w_access    = (r_state == S_ACCESS);
    assign stall       = clear & (((r_state == S_IDLE) & req_valid) | w_access);
    assign mem_req     = w_access;
    assign mem_we      = w_access & r_write;
    assign mem_addr    = w_access ? (r_base + ADDR_WIDTH'(r_count)) : '0;
    assign mem_wdata   = w_access ? r_wdata[{r_count, 3'b000} +: 8] : 8'd0;
    assign rdata       = r_rdata;
    assign rdata_valid = (r_state == S_DONE) & ~r_err & ~r_write;
    assign misaligned  = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: byte memory responder with
// programmable ack delay plus an arithmetic reference model of loads/stores.
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;

    load_store_unit #(.ADDR_WIDTH(8)) dut (
        .clock       (clock),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misaligned  (misaligned),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    always #5 clock = ~clock;

    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];
    logic [16:0] txq[$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_rdata = 32'd0;

    // Memory responder: acks after ack_delay wait cycles, logs each accepted byte.
    always @(negedge clock) begin
        if (mem_req && wait_cnt >= ack_delay) begin
            mem_ack   = 1'b1;
            mem_rdata = mem[mem_addr];
            txq.push_back({mem_we, mem_addr, mem_wdata});
            if (mem_we) mem[mem_addr] = mem_wdata;
            wait_cnt  = 0;
        end else begin
            mem_ack   = 1'b0;
            mem_rdata = 8'($urandom);
            wait_cnt  = mem_req ? wait_cnt + 1 : 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input bit wr, input bit [2:0] f3, input bit [31:0] a,
                          input bit [31:0] wd, input int dly);
        int              n;
        bit              bad;
        bit              done;
        int              stall_cnt;
        int              req_cnt;
        longint unsigned v;
        logic [16:0]     exp_tx[$];

        n   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
        bad = (n == 0) || ((a % n) != 0);
        if (!bad) begin
            v = 0;
            for (int i = 0; i < n; i++) begin
                exp_tx.push_back({wr, 8'((a + i) % 256), 8'((wd >> (8 * i)) % 256)});
                if (wr) exp_mem[(a + i) % 256] = 8'((wd >> (8 * i)) % 256);
                else    v = v + (longint'(exp_mem[(a + i) % 256]) << (8 * i));
            end
            if (!wr) begin
                if (!f3[2] && n < 4 && v >= (64'd1 << (8 * n - 1)))
                    v = v + 64'h1_0000_0000 - (64'd1 << (8 * n));
                exp_rdata = 32'(v);
            end
        end

        txq.delete();
        ack_delay = dly;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = wr; funct3 = f3; addr = a; wdata = wd;
        done = 0; stall_cnt = 0; req_cnt = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (mem_req) req_cnt++;
            if (stall) stall_cnt++;
            else begin
                done = 1;
                check("done_rdata_valid", 32'(rdata_valid), 32'(!bad && !wr));
                check("done_misaligned", 32'(misaligned), 32'(bad));
                check("done_rdata", rdata, exp_rdata);
            end
        end
        check("done_reached", 32'(done), 32'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(negedge clock);
        check("pulse_end", {29'd0, rdata_valid, misaligned, stall}, 32'd0);
        check("stall_cycles", stall_cnt, bad ? 1 : 1 + n * (dly + 1));
        check("mem_req_cycles", req_cnt, bad ? 0 : n * (dly + 1));
        check("txn_count", txq.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < txq.size(); i++)
            check("txn_we_addr_data", 32'(txq[i]), 32'(exp_tx[i]));
    endtask

    initial begin
        int diffs;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        mem[8'h10] = 8'h34; mem[8'h11] = 8'h12; mem[8'h12] = 8'hFF; mem[8'h13] = 8'h80;
        for (int i = 16; i < 20; i++) exp_mem[i] = mem[i];

        repeat (3) @(posedge clock);
        #1;
        check("reset_outputs", {26'd0, stall, rdata_valid, misaligned, mem_req, mem_we, 1'b0}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        clear = 1'b1;

        run_op(0, 3'b010, 32'h10, 32'h0, 0);
        check("lw_spec_value", rdata, 32'h80FF1234);
        run_op(0, 3'b000, 32'h13, 32'h0, 0);
        check("lb_spec_value", rdata, 32'hFFFFFF80);
        run_op(0, 3'b100, 32'h13, 32'h0, 1);
        check("lbu_spec_value", rdata, 32'h00000080);
        run_op(0, 3'b001, 32'h12, 32'h0, 0);
        check("lh_spec_value", rdata, 32'hFFFF80FF);
        run_op(0, 3'b101, 32'h12, 32'h0, 2);
        check("lhu_spec_value", rdata, 32'h000080FF);
        run_op(1, 3'b010, 32'h20, 32'hDEADBEEF, 2);
        check("sw_rdata_kept", rdata, 32'h000080FF);
        run_op(1, 3'b001, 32'h21, 32'h5555AAAA, 0);
        run_op(0, 3'b010, 32'h22, 32'h0, 0);
        run_op(0, 3'b011, 32'h30, 32'h0, 0);
        run_op(1, 3'b010, 32'h1FC, 32'hCAFEF00D, 0);
        run_op(0, 3'b010, 32'hFC, 32'h0, 1);
        check("wrap_readback", rdata, 32'hCAFEF00D);

        // Reset in the middle of a word store: only the first two bytes land.
        txq.delete();
        ack_delay = 0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b1; funct3 = 3'b010; addr = 32'h1FC; wdata = 32'h11223344;
        repeat (3) @(posedge clock);
        #1;
        clear = 1'b0; req_valid = 1'b0;
        exp_mem[8'hFC] = 8'h44; exp_mem[8'hFD] = 8'h33;
        exp_rdata = 32'd0;
        #1;
        check("midreset_outputs", {27'd0, stall, rdata_valid, misaligned, mem_req, mem_we}, 32'd0);
        check("midreset_mem_bus", {16'd0, mem_addr, mem_wdata}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        check("midreset_txn_count", txq.size(), 2);
        check("midreset_bytes", {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]},
              {exp_mem[8'hFC], exp_mem[8'hFD], exp_mem[8'hFE], exp_mem[8'hFF]});
        check("midreset_idle", {31'd0, mem_req}, 32'd0);

        for (int k = 0; k < 40; k++) begin
            logic [31:0] ra;
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
            run_op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom,
                   $urandom_range(0, 2));
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) diffs++;
        check("final_mem_image", diffs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
